// File: rtl/decode_sequencer_if.sv
// rtl/decode_sequencer_if.sv - opcode/irq/control bundle for decode_sequencer (DECODER_IRQ_MASK_EN adds mask ports)
interface decode_sequencer_if #(
  parameter int OPCODE_W = 5,
  parameter int NUM_IRQ  = 4
);
  localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [OPCODE_W-1:0] opcode;
  logic                valid;
  logic [NUM_IRQ-1:0]  irq;
`ifdef DECODER_IRQ_MASK_EN
  logic                mask_we;
  logic [NUM_IRQ-1:0]  mask_data;
`endif
  logic                int_mux;
  logic                pc_save;
  logic                mem_write;
  logic [1:0]          pc_mux;
  logic [1:0]          w_mux;
  logic [3:0]          alu_op;
  logic [IRQ_W-1:0]    irq_id;
  logic                in_service;
  logic                illegal;

`ifdef DECODER_IRQ_MASK_EN
  modport master (
    output opcode, valid, irq, mask_we, mask_data,
    input  int_mux, pc_save, mem_write, pc_mux, w_mux, alu_op, irq_id, in_service, illegal
  );
  modport slave (
    input  opcode, valid, irq, mask_we, mask_data,
    output int_mux, pc_save, mem_write, pc_mux, w_mux, alu_op, irq_id, in_service, illegal
  );
`else
  modport master (
    output opcode, valid, irq,
    input  int_mux, pc_save, mem_write, pc_mux, w_mux, alu_op, irq_id, in_service, illegal
  );
  modport slave (
    input  opcode, valid, irq,
    output int_mux, pc_save, mem_write, pc_mux, w_mux, alu_op, irq_id, in_service, illegal
  );
`endif
endinterface

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - registered opcode decoder with wfi/rfi interrupt sequencer (DECODER_IRQ_MASK_EN enables irq mask register)
module decode_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int NUM_IRQ  = 4
) (
  input logic               clk,
  input logic               rst_n,
  decode_sequencer_if.slave bus
);
  localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ISR} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] irq_prev, pending, enable, avail, clr;
  logic [IRQ_W-1:0]   sel;
  logic               op_illegal;
  logic               take;

  logic [1:0] d_w, d_pc;
  logic       d_mw, d_ps;
  logic [3:0] d_alu;

  logic [1:0]       n_w, n_pc;
  logic             n_mw, n_ps, n_int, n_ill, n_insvc;
  logic [3:0]       n_alu;
  logic [IRQ_W-1:0] n_id;

  generate
    if (OPCODE_W > 5) begin : g_wide
      assign op_illegal = |bus.opcode[OPCODE_W-1:5];
    end else begin : g_narrow
      assign op_illegal = 1'b0;
    end
  endgenerate

`ifdef DECODER_IRQ_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           enable <= '0;
    else if (bus.mask_we) enable <= bus.mask_data;
  end
`else
  assign enable = '1;
`endif

  assign avail = pending & enable;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (avail[i]) sel = IRQ_W'(i);
    end
  end

  always_comb begin
    d_w   = 2'd3;
    d_mw  = 1'b0;
    d_pc  = 2'd0;
    d_ps  = 1'b0;
    d_alu = 4'hA;
    case (bus.opcode[4:1])
      4'h0: begin
        d_alu = 4'h7;
        if (bus.opcode[0]) d_mw = 1'b1;
        else               d_w  = 2'd1;
      end
      4'h1: d_mw = 1'b1;
      4'h2: d_w  = 2'd2;
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        d_w  = bus.opcode[0] ? 2'd3 : 2'd0;
        d_mw = bus.opcode[0];
        case (bus.opcode[4:1])
          4'h3:    d_alu = 4'h0;
          4'h4:    d_alu = 4'h1;
          4'h5:    d_alu = 4'h4;
          4'h6:    d_alu = 4'h5;
          4'h7:    d_alu = 4'h6;
          4'h8:    d_alu = 4'h2;
          default: d_alu = 4'h3;
        endcase
      end
      4'hA: d_alu = 4'h8;
      4'hB: d_alu = 4'h9;
      4'hC: d_pc  = 2'd2;
      4'hD: d_pc  = 2'd1;
      4'hE: begin
        d_pc = 2'd3;
        d_ps = 1'b1;
      end
      default: d_pc = 2'd3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    n_w       = 2'd3;
    n_mw      = 1'b0;
    n_pc      = 2'd0;
    n_ps      = 1'b0;
    n_alu     = 4'hA;
    n_int     = 1'b0;
    n_ill     = 1'b0;
    n_id      = bus.irq_id;
    n_insvc   = bus.in_service;
    clr       = '0;
    take      = 1'b0;
    case (state)
      S_RUN: begin
        if (bus.valid) begin
          if (|avail) begin
            take = 1'b1;
          end else if (op_illegal) begin
            n_ill = 1'b1;
          end else begin
            n_w = d_w; n_mw = d_mw; n_pc = d_pc; n_ps = d_ps; n_alu = d_alu;
            if (bus.opcode[4:1] == 4'hE) state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (|avail) take = 1'b1;
      end
      S_ISR: begin
        if (bus.valid) begin
          if (op_illegal) begin
            n_ill = 1'b1;
          end else begin
            n_w = d_w; n_mw = d_mw; n_pc = d_pc; n_ps = d_ps; n_alu = d_alu;
            if (bus.opcode[4:1] == 4'hF) begin
              n_insvc   = 1'b0;
              state_nxt = S_RUN;
            end
          end
        end
      end
      default: state_nxt = S_RUN;
    endcase
    // Taking an interrupt drops the presented opcode; fetch replays it after rfi.
    if (take) begin
      n_int     = 1'b1;
      n_pc      = 2'd3;
      n_ps      = 1'b1;
      n_id      = sel;
      clr       = NUM_IRQ'(1) << sel;
      n_insvc   = 1'b1;
      state_nxt = S_ISR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  // A new edge beats the clear of the bit being taken in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= bus.irq;
      pending  <= (pending & ~clr) | (bus.irq & ~irq_prev);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.w_mux      <= 2'd3;
      bus.mem_write  <= 1'b0;
      bus.pc_mux     <= 2'd0;
      bus.pc_save    <= 1'b0;
      bus.alu_op     <= 4'hA;
      bus.int_mux    <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.irq_id     <= '0;
      bus.in_service <= 1'b0;
    end else begin
      bus.w_mux      <= n_w;
      bus.mem_write  <= n_mw;
      bus.pc_mux     <= n_pc;
      bus.pc_save    <= n_ps;
      bus.alu_op     <= n_alu;
      bus.int_mux    <= n_int;
      bus.illegal    <= n_ill;
      bus.irq_id     <= n_id;
      bus.in_service <= n_insvc;
    end
  end
endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_W, default 5, meaning opcode width (>=5); any set bit above [4:0] marks an illegal opcode.
REQ-002 SHALL have parameter NUM_IRQ, default 4, meaning interrupt channel count (1..16); IRQ_W = max(1, clog2(NUM_IRQ)).
REQ-003 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  OPCODE_W  instruction opcode
- valid  input  1  opcode valid this cycle
- irq  input  NUM_IRQ  interrupt request lines, rising-edge sensitive
- mask_we  input  1  mask load strobe (DECODER_IRQ_MASK_EN only)
- mask_data  input  NUM_IRQ  enable mask value (DECODER_IRQ_MASK_EN only)
- int_mux, pc_save, mem_write  output  1 each  control strobes
- pc_mux, w_mux  output  2 each  PC/W source selects
- alu_op  output  4  ALU operation
- irq_id  output  IRQ_W  channel taken
- in_service  output  1  ISR active
- illegal  output  1  illegal opcode flagged

Function
REQ-004 SHALL register all outputs; decode of the opcode sampled at clock edge N SHALL be visible after edge N (1-cycle latency).
REQ-005 SHALL define a NOP bundle: w_mux=3, mem_write=0, pc_mux=0, pc_save=0, alu_op=0xA, int_mux=0; the NOP bundle SHALL be output whenever valid=0.
REQ-006 SHALL decode opcode[4:1] as follows; "dual" means w_mux=0 (ALU), mem_write=0 when opcode[0]=0, and w_mux=3, mem_write=1 when opcode[0]=1:
- 0x0: w_mux=1 (or 3 with mem_write=1 if opcode[0]), alu_op=7
- 0x1: w_mux=3, mem_write=1, alu_op=0xA
- 0x2: w_mux=2, alu_op=0xA
- 0x3..0x9: dual, alu_op 0,1,4,5,6,2,3 respectively
- 0xA: alu_op=8
- 0xB: alu_op=9
- 0xC: pc_mux=2
- 0xD: pc_mux=1
- 0xE (wfi): pc_mux=3, pc_save=1
- 0xF (rfi): pc_mux=3
All fields not listed take NOP-bundle values.
REQ-007 An illegal opcode with valid=1 SHALL output the NOP bundle and set illegal=1 for one cycle; it SHALL cause no state change.
REQ-008 SHALL set pending[i] when irq[i]=1 and its registered previous value is 0; if set and clear coincide, set SHALL win.
REQ-009 SHALL implement a 3-state FSM: RUN, WAIT, ISR.
REQ-010 RUN: decode normally; a valid wfi SHALL output the REQ-006 wfi decode and move to WAIT.
REQ-011 WAIT: valid SHALL be ignored and the NOP bundle output until an interrupt is taken.
REQ-012 An interrupt SHALL be taken in RUN (only while valid=1) or in WAIT (any cycle) when pending&enable is nonzero.
REQ-013 When an interrupt is taken, the decoder SHALL:
- select the lowest-index channel
- output the NOP bundle except int_mux=1, pc_mux=3, pc_save=1
- load irq_id with the selected channel and clear its pending bit
- set in_service=1 and move to ISR
- discard the presented opcode (fetch replays it)
REQ-014 ISR: decode normally with no nesting (new edges stay pending); a valid rfi SHALL output the rfi decode, clear in_service and move to RUN.
REQ-015 rfi in RUN SHALL be decoded normally with no state change.
REQ-016 irq_id SHALL hold its value until the next interrupt is taken.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- all outputs to the NOP bundle
- irq_id=0, in_service=0, illegal=0
- pending=0, previous irq=0
- FSM=RUN
A line already high at reset release SHALL register as an edge on the first clock.
REQ-018 Reset SHALL override any in-progress WAIT/ISR without completing it.

Configuration
REQ-019 With DECODER_IRQ_MASK_EN defined:
- mask_we/mask_data ports SHALL exist
- the enable register SHALL reset to all zeros and load mask_data when mask_we=1
- masked channels SHALL keep pending latched and be taken once unmasked
REQ-020 Without DECODER_IRQ_MASK_EN, the mask ports SHALL be absent and enable SHALL be all ones.

Verification
REQ-021 opcode=0x11 (add, bit0=1), valid=1 -> next cycle w_mux=3, mem_write=1, alu_op=2, pc_mux=0.
REQ-022 Reset release, RUN, irq=4'b1010 rising, valid=1 -> int_mux=1, pc_mux=3, pc_save=1, irq_id=1, in_service=1; pending[3] remains set.
REQ-023 wfi (0x1C) then 5 idle cycles with valid=1 -> NOP bundle each cycle; irq[2] rise -> interrupt taken with irq_id=2.
REQ-024 In ISR, irq[0] rises -> no int_mux; after rfi (0x1E) -> in_service=0; next valid cycle -> taken with irq_id=0.
REQ-025 OPCODE_W=7, opcode=7'h40 -> illegal=1 for one cycle with NOP bundle; assert rst_n low while in ISR -> in_service=0 and FSM=RUN immediately.
